// File: rtl/odd_cnt_seq_ctrl.sv
// Burst sequencer for the odd-value counter: emits len odd values from seed|1
// in steps of 2 over a valid/ready stream, with pause, abort and a done pulse.
module odd_cnt_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             pause_i,
  input  logic             abort_i,
  input  logic             cnt_rdy_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             cnt_vld_o,
  output logic [LEN_W-1:0] remain_o,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic             vld_q, ready_q, busy_q, done_q;
  logic             beat;

  assign beat = vld_q & cnt_rdy_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    remain_d = remain_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            cnt_d    = seed_i | WIDTH'(1);
            remain_d = len_i;
            state_d  = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        // Abort outranks both completion and pause; a beat in the same cycle
        // is still counted as transferred by the consumer.
        if (abort_i) begin
          remain_d = '0;
          state_d  = IDLE;
        end else if (beat) begin
          if (remain_q == LEN_W'(1)) begin
            remain_d = '0;
            state_d  = DONE;
          end else begin
            cnt_d    = cnt_q + WIDTH'(2);
            remain_d = remain_q - LEN_W'(1);
            state_d  = pause_i ? PAUSE : RUN;
          end
        end else if (pause_i) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (abort_i) begin
          remain_d = '0;
          state_d  = IDLE;
        end else if (!pause_i) begin
          state_d = RUN;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      remain_q <= '0;
      vld_q    <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      remain_q <= remain_d;
      vld_q    <= (state_d == RUN);
      ready_q  <= (state_d == IDLE);
      busy_q   <= (state_d == RUN) || (state_d == PAUSE);
      done_q   <= (state_d == DONE);
    end
  end

  assign cnt_o     = cnt_q;
  assign cnt_vld_o = vld_q;
  assign remain_o  = remain_q;
  assign ready_o   = ready_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule
